sdram_pll_sequencer: RTL and testbench

//   Sequences the 143 MHz SDRAM PLL from the free-running 50 MHz refclk domain:

---
 rtl/sdram_pll_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/sdram_pll_sequencer.sv | 123 ++++++++++++
 tb/tb_sdram_pll_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pll_pkg.sv
// Shared types and constants for the SDRAM PLL start-up sequencer.
// Holds the state encoding, the default cycle counts and the timer width helper.
package sdram_pll_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    POWERUP    = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } pll_state_e;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_PWRUP_CYCLES = 10000;
  localparam int DEF_MAX_RETRIES  = 3;

  // One timer serves every state, so it is sized for the longest wait.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for single-bit level signals crossing into the local clock.
// Also used for the reset synchronisers in the PLL output clock domains.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_sequencer.sv
// Brings up the SDRAM PLL from refclk: resets it, qualifies lock, retries on timeout,
// waits out SDRAM power-up and only then releases the SDRAM-domain reset.
module sdram_pll_sequencer
  import sdram_pll_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int PWRUP_CYCLES = DEF_PWRUP_CYCLES,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sdram_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, PWRUP_CYCLES);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] PWRUP_LAST  = TW'(PWRUP_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  logic          lock_s;
  pll_state_e    state;
  pll_state_e    state_nxt;
  logic [TW-1:0] timer;
  logic          retry_inc;
  logic          retry_clr;
  logic          loss_inc;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state and counter events; restart overrides whatever lock is doing.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    loss_inc  = 1'b0;
    if (restart) begin
      state_nxt = RESET_HOLD;
      retry_clr = 1'b1;
    end else begin
      case (state)
        RESET_HOLD: if (timer == RST_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (timer == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAULT;
            end else begin
              retry_inc = 1'b1;
              state_nxt = RESET_HOLD;
            end
          end
        end
        STABLE: begin
          if (!lock_s) state_nxt = WAIT_LOCK;
          else if (timer == STABLE_LAST) state_nxt = POWERUP;
        end
        POWERUP: begin
          if (!lock_s) begin
            loss_inc  = 1'b1;
            state_nxt = RESET_HOLD;
          end else if (timer == PWRUP_LAST) begin
            retry_clr = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (!lock_s) begin
            loss_inc  = 1'b1;
            state_nxt = RESET_HOLD;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RESET_HOLD;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_HOLD;
      timer         <= '0;
      retry_cnt     <= 2'd0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      sdram_rst_n   <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= (restart || (state_nxt != state)) ? '0 : timer + TW'(1);
      if (retry_clr) retry_cnt <= 2'd0;
      else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
      if (loss_inc && (lock_loss_cnt != 8'hFF)) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      pll_rst     <= (state_nxt == RESET_HOLD) || (state_nxt == FAULT);
      sdram_rst_n <= (state_nxt == RUN);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_sdram_pll_sequencer.sv
// Bench for sdram_pll_sequencer: directed bring-up scenarios plus randomized lock traffic,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_sdram_pll_sequencer;

  localparam int RST     = 4;
  localparam int TOUT    = 20;
  localparam int STB     = 8;
  localparam int PWR     = 10;
  localparam int RETRIES = 3;
  // Edges from the first edge sampling a new pll_locked value until the FSM acts on it.
  localparam int SYNC_ACT = 3;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sdram_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: phase number, cycles spent in the phase, counters, synchroniser pipe.
  int m_phase;
  int m_age;
  int m_retry;
  int m_loss;
  bit lock_pipe[$];

  always #5 refclk = ~refclk;

  sdram_pll_sequencer #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TOUT),
    .LOCK_STABLE  (STB),
    .PWRUP_CYCLES (PWR),
    .MAX_RETRIES  (RETRIES)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .sdram_rst_n   (sdram_rst_n),
    .ready         (ready),
    .fault         (fault),
    .state_o       (state_o),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = 0;
    m_age   = 1;
    m_retry = 0;
    m_loss  = 0;
    lock_pipe = {1'b0, 1'b0};
  endtask

  task automatic modelStep(input bit lk, input bit rs);
    bit seen;
    int nxt;
    seen = lock_pipe.pop_front();
    lock_pipe.push_back(lk);
    nxt = m_phase;
    if (rs) begin
      nxt = 0;
      m_retry = 0;
    end else begin
      case (m_phase)
        0: if (m_age == RST) nxt = 1;
        1: begin
          if (seen) nxt = 2;
          else if (m_age == TOUT) begin
            if (m_retry == RETRIES) nxt = 5;
            else begin
              m_retry++;
              nxt = 0;
            end
          end
        end
        2: begin
          if (!seen) nxt = 1;
          else if (m_age == STB) nxt = 3;
        end
        3: begin
          if (!seen) begin
            if (m_loss < 255) m_loss++;
            nxt = 0;
          end else if (m_age == PWR) begin
            m_retry = 0;
            nxt = 4;
          end
        end
        4: begin
          if (!seen) begin
            if (m_loss < 255) m_loss++;
            nxt = 0;
          end
        end
        default: nxt = m_phase;
      endcase
    end
    m_age   = (rs || nxt != m_phase) ? 1 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic checkAll();
    checkOutput("state_o", state_o, m_phase);
    checkOutput("pll_rst", pll_rst, (m_phase == 0) || (m_phase == 5));
    checkOutput("sdram_rst_n", sdram_rst_n, m_phase == 4);
    checkOutput("ready", ready, m_phase == 4);
    checkOutput("fault", fault, m_phase == 5);
    checkOutput("retry_cnt", retry_cnt, m_retry);
    checkOutput("lock_loss_cnt", lock_loss_cnt, m_loss);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"}, pll_rst, 1);
    checkOutput({tag, "_sdram_rst_n"}, sdram_rst_n, 0);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_state"}, state_o, 0);
    checkOutput({tag, "_retry"}, retry_cnt, 0);
    checkOutput({tag, "_loss"}, lock_loss_cnt, 0);
  endtask

  // One refclk cycle: drive inputs away from the edge, advance the model, check after the edge.
  task automatic applyStimulus(input bit lk, input bit rs);
    pll_locked = lk;
    restart    = rs;
    @(posedge refclk);
    modelStep(lk, rs);
    #1;
    checkAll();
  endtask

  task automatic runUntilPhase(input string tag, input int target, input bit lk, input int budget);
    int n;
    n = 0;
    while (m_phase != target && n < budget) begin
      applyStimulus(lk, 1'b0);
      n++;
    end
    checkOutput(tag, state_o, target);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int falls;
    int width;
    int run_len;
    bit lk;
    logic prev_rst;

    rst_n = 1'b0;
    pll_locked = 1'b0;
    restart = 1'b0;
    modelReset();
    #23;
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] scenario 1: clean lock");
    runUntilPhase("t1_wait_lock", 1, 1'b0, 50);
    repeat (4) applyStimulus(1'b0, 1'b0);
    lat = 0;
    do begin
      applyStimulus(1'b1, 1'b0);
      lat++;
    end while (ready !== 1'b1 && lat < 100);
    checkOutput("t1_latency", lat, SYNC_ACT + STB + PWR);
    checkOutput("t1_sdram_rst_n", sdram_rst_n, 1);
    checkOutput("t1_retry", retry_cnt, 0);

    $display("[TB] scenario 3: lock glitch in STABLE");
    applyStimulus(1'b1, 1'b1);
    runUntilPhase("t3_stable", 2, 1'b1, 50);
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    lat = 0;
    do begin
      applyStimulus(1'b1, 1'b0);
      lat++;
    end while (ready !== 1'b1 && lat < 100);
    checkOutput("t3_latency", lat, SYNC_ACT + STB + PWR);
    checkOutput("t3_loss", lock_loss_cnt, 0);

    $display("[TB] scenario 4: lock loss in RUN");
    repeat (3) applyStimulus(1'b1, 1'b0);
    lat = 0;
    do begin
      applyStimulus(1'b0, 1'b0);
      lat++;
    end while (ready !== 1'b0 && lat < 20);
    checkOutput("t4_latency", lat, SYNC_ACT);
    checkOutput("t4_sdram_rst_n", sdram_rst_n, 0);
    checkOutput("t4_loss", lock_loss_cnt, 1);
    checkOutput("t4_state", state_o, 0);

    $display("[TB] scenario 2: lock never asserts");
    applyStimulus(1'b0, 1'b1);
    falls = 0;
    width = 0;
    prev_rst = pll_rst;
    for (int i = 0; i < 400 && m_phase != 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (prev_rst === 1'b1) width++;
      if (prev_rst === 1'b1 && pll_rst === 1'b0) begin
        falls++;
        checkOutput("t2_rst_width", width, RST);
      end
      if (pll_rst === 1'b0) width = 0;
      prev_rst = pll_rst;
    end
    checkOutput("t2_attempts", falls, RETRIES + 1);
    checkOutput("t2_fault", fault, 1);
    checkOutput("t2_pll_rst", pll_rst, 1);
    checkOutput("t2_state", state_o, 5);
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("t2_fault_held", state_o, 5);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_restart_state", state_o, 0);
    checkOutput("t2_restart_retry", retry_cnt, 0);

    $display("[TB] scenario 5: repeated lock loss saturates");
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      runUntilPhase("t5_run", 4, 1'b1, 100);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end
    checkOutput("t5_saturated", lock_loss_cnt, 255);

    $display("[TB] scenario 6: async reset and restart precedence");
    applyStimulus(1'b1, 1'b1);
    runUntilPhase("t6_powerup", 3, 1'b1, 50);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("t6_async");
    modelReset();
    #2;
    rst_n = 1'b1;
    runUntilPhase("t6_run", 4, 1'b1, 100);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_restart_state", state_o, 0);
    checkOutput("t6_restart_loss", lock_loss_cnt, 0);

    $display("[TB] randomized lock traffic");
    run_len = 0;
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_len == 0) begin
        lk = ($urandom_range(0, 3) != 0);
        run_len = $urandom_range(1, 40);
      end
      run_len--;
      applyStimulus(lk, ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
